qspi_initiator: RTL
===================

Name: qspi_initiator

Overview:
Quad-SPI initiator (master) driving QSS/QCK/QD[3:0] toward a QSPI target, such as the SoC-side QSPI peripheral. It is the opposite end of the link that the Murax top level exposes as inputs QSS/QCK and bidirectional QD. Used for FPGA-side loopback, bring-up and co-processor emulation. Transactions are one opcode byte followed by 0..2^LEN_W-1 data bytes, written or read. Pad tristating is done outside via SB_IO using qd_out/qd_oe/qd_in.

Parameters:
CLK_DIV, 2, QCK half-period in CLK cycles; legal range >=1
LEN_W, 8, width of cmd_len
DUMMY_CYCLES, 2, turnaround QCK cycles before read data; legal range >=1

Ports:
CLK  in  1  system clock
reset_in  in  1  async active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_opcode  in  8  opcode byte
cmd_read  in  1  1=read data phase, 0=write
cmd_len  in  LEN_W  data byte count
tx_data  in  8  write byte
tx_valid  in  1  write byte valid
tx_ready  out  1  1-cycle pulse when tx_data is consumed
rx_data  out  8  read byte
rx_valid  out  1  read byte held until rx_ready
rx_ready  in  1  consumer accept
busy  out  1  state != IDLE
done  out  1  1-cycle pulse when QSS deasserts
err  out  1  sticky; cleared on command accept
qss  out  1  active-low select
qck  out  1  serial clock, idle low (mode 0)
qd_out  out  4  nibble out
qd_oe  out  4  all-ones when driving, else 0
qd_in  in  4  pad input

Behaviour:
- Clock and reset: CLK, async active-high reset_in (decided). Reset mid-transfer aborts immediately.
- Reset values: qss=1, qck=0, qd_oe=0, qd_out=0, rx_valid=0, rx_data=0, busy=0, done=0, err=0, tx_ready=0, cmd_ready=1.
- Tick generator: divider counts 0..CLK_DIV-1. On each terminal count, qck toggles if the current phase clocks.
- Nibble order: high nibble first. Target samples on rising QCK. Initiator changes qd_out on falling QCK and samples qd_in in the CLK cycle in which qck rises.
- FSM states: IDLE, SETUP, CMD, TURN, WDATA, RDATA, HOLD, DESEL.
- IDLE:
  - Handshake is cmd_valid&&cmd_ready.
  - On handshake: latch opcode, rw, len; clear err; qss<=0; qd_oe<=F; qd_out<=opcode[7:4]; go to SETUP.
- SETUP: wait one half-period, then go to CMD.
- CMD:
  - Two QCK cycles; low nibble is presented on the first falling edge.
  - After the second rising edge: if len==0, go to HOLD; otherwise go to WDATA (write) or TURN (read).
- WDATA:
  - On a byte boundary at a falling edge, take tx_data and pulse tx_ready. Per-byte flow is governed by QSPI_STALL_EN.
  - Decrement the remaining count after each byte. Go to HOLD after the last byte's second rising edge.
- TURN: qd_oe=0 from the falling edge after CMD; DUMMY_CYCLES full QCK cycles; then go to RDATA.
- RDATA:
  - Two rising-edge samples form each byte.
  - On the second sample: rx_data<=byte, rx_valid<=1.
  - rx_valid clears on rx_valid&&rx_ready.
- HOLD: qck held low for one half-period; qd_oe<=0; qss<=1; done pulse; go to DESEL.
- DESEL: qss high for at least 2*CLK_DIV CLK cycles, then go to IDLE.
- cmd_len counts use LEN_W-bit unsigned arithmetic; no wrap. Max len = 2^LEN_W-1.
- cmd_valid during busy: ignored. The command is held by the requester, since cmd_ready=0.

Optional Feature:
Macro QSPI_STALL_EN.
- Defined:
  - Tx underrun (tx_valid=0 when a byte is needed): qck freezes low and the divider is held until tx_valid=1.
  - Rx full (rx_valid=1 with no rx_ready at the first rising edge of the next byte): clock freezes until rx_ready.
  - err is never set.
- Undefined:
  - Tx underrun: sends 0x00 with no tx_ready pulse and sets err.
  - Rx overrun: rx_data is overwritten, rx_valid stays 1, err is set.
  - Clock never stops mid-frame.

Decomposition:
- Shared package qspi_pkg:
  - state enum for the FSM.
  - QSPI_NIBBLE_W=4.
  - QSPI_OE_ON=4'hF.
  - opcode constants used by the link: 8'h02 write, 8'h0B read.
- One sub-module, qspi_clk_gen, holds the divider, qck toggle, rise/fall strobes and a freeze input.

Test Plan:
- Write: CLK_DIV=2, cmd 02 write len 2, tx A5,3C always valid -> qd_out sequence 0,2,A,5,3,C; 6 rising edges; tx_ready pulses twice; done pulse; qss low for 6 QCK periods plus setup/hold.
- Read: cmd 0B read len 1, DUMMY_CYCLES=2; model drives 7 then E on rising edges after turnaround -> qd_oe=0 from the TURN falling edge; rx_data=7E, rx_valid=1 until rx_ready.
- Zero length: cmd 55 read len 0 -> no TURN phase; exactly 2 QCK cycles; done pulse; rx_valid stays 0.
- Underrun: len 2, tx_valid dropped for 10 cycles before byte 2.
  - STALL_EN: qck low 10+ cycles, then 2nd byte correct, err=0.
  - Without: 2nd byte 00, err=1.
- Abort: reset_in asserted during WDATA byte 1 -> same cycle qss=1, qck=0, qd_oe=0, busy=0. Next command completes normally.
- Back-to-back: second cmd_valid held high during busy -> accepted only after DESEL; qss high for >=4 CLK between frames.

Source files
------------

// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================================
// qspi_pkg : shared types and constants for the QSPI initiator
// Rev 1.0
// ============================================================================
package qspi_pkg;

  localparam int                       QSPI_NIBBLE_W = 4;
  localparam logic [QSPI_NIBBLE_W-1:0] QSPI_OE_ON    = 4'hF;
  localparam logic [7:0]               QSPI_OP_WRITE = 8'h02;
  localparam logic [7:0]               QSPI_OP_READ  = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_TURN  = 3'd3,
    ST_WDATA = 3'd4,
    ST_RDATA = 3'd5,
    ST_HOLD  = 3'd6,
    ST_DESEL = 3'd7
  } qspi_state_e;

endpackage
`default_nettype wire

// File: rtl/qspi_clk_gen.sv
`default_nettype none
// ============================================================================
// qspi_clk_gen : half-period divider, QCK toggle and rise/fall strobes
// Rev 1.0
// ============================================================================
module qspi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic reset_in,
  input  logic run_i,
  input  logic clk_en_i,
  input  logic freeze_i,
  output logic qck_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             qck_q, qck_d;
  logic             tick;

  assign tick = run_i && !freeze_i && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    qck_d = qck_q;
    if (!run_i) begin
      div_d = '0;
      qck_d = 1'b0;
    end else if (!freeze_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
    if (tick && clk_en_i) qck_d = ~qck_q;
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      div_q <= '0;
      qck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      qck_q <= qck_d;
    end
  end

  assign qck_o  = qck_q;
  assign tick_o = tick;
  assign rise_o = tick && clk_en_i && !qck_q;
  assign fall_o = tick && clk_en_i &&  qck_q;

endmodule
`default_nettype wire

// File: rtl/qspi_initiator.sv
`default_nettype none
// ============================================================================
// qspi_initiator : quad-SPI master, opcode byte plus 0..2^LEN_W-1 data bytes
// QSPI_STALL_EN freezes QCK on tx underrun / rx full instead of flagging err.
// Rev 1.0
// ============================================================================
module qspi_initiator
  import qspi_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int LEN_W        = 8,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     reset_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_opcode,
  input  logic                     cmd_read,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     qss,
  output logic                     qck,
  output logic [QSPI_NIBBLE_W-1:0] qd_out,
  output logic [QSPI_NIBBLE_W-1:0] qd_oe,
  input  logic [QSPI_NIBBLE_W-1:0] qd_in
);

  localparam int                TURN_W    = $clog2(DUMMY_CYCLES + 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(DUMMY_CYCLES);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  qspi_state_e              state_q;
  logic                     rw_q, nib_q, qss_q, rx_valid_q, tx_ready_q, done_q, err_q;
  logic [LEN_W-1:0]         rem_q;
  logic [TURN_W-1:0]        turn_q;
  logic [7:0]               byte_q, rx_data_q;
  logic [QSPI_NIBBLE_W-1:0] qd_out_q, qd_oe_q;
  logic                     tick, rise, fall, clk_en, freeze;
`ifdef QSPI_STALL_EN
  logic                     need_q;
`endif

  always_comb begin
    clk_en = 1'b0;
    case (state_q)
      ST_CMD, ST_TURN, ST_WDATA, ST_RDATA: clk_en = 1'b1;
      ST_HOLD:                             clk_en = qck;  // only the closing fall
      default:                             clk_en = 1'b0;
    endcase
  end

`ifdef QSPI_STALL_EN
  assign freeze = need_q ||
                  ((state_q == ST_RDATA) && !nib_q && !qck && rx_valid_q && !rx_ready);
`else
  assign freeze = 1'b0;
`endif

  qspi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CLK      (CLK),
    .reset_in (reset_in),
    .run_i    (state_q != ST_IDLE),
    .clk_en_i (clk_en),
    .freeze_i (freeze),
    .qck_o    (qck),
    .tick_o   (tick),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      nib_q      <= 1'b0;
      qss_q      <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rem_q      <= '0;
      turn_q     <= '0;
      byte_q     <= '0;
      rx_data_q  <= '0;
      qd_out_q   <= '0;
      qd_oe_q    <= '0;
`ifdef QSPI_STALL_EN
      need_q     <= 1'b0;
`endif
    end else begin
      tx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          byte_q   <= cmd_opcode;
          rw_q     <= cmd_read;
          rem_q    <= cmd_len;
          err_q    <= 1'b0;
          qss_q    <= 1'b0;
          qd_oe_q  <= QSPI_OE_ON;
          qd_out_q <= cmd_opcode[7:4];
          nib_q    <= 1'b0;
          turn_q   <= '0;
          state_q  <= ST_SETUP;
        end
        ST_SETUP: if (tick) state_q <= ST_CMD;
        ST_CMD: begin
          if (fall) begin
            qd_out_q <= byte_q[3:0];
          end else if (rise) begin
            nib_q <= ~nib_q;
            if (nib_q) begin
              if (rem_q == '0) state_q <= ST_HOLD;
              else if (rw_q)   state_q <= ST_TURN;
              else             state_q <= ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
`ifdef QSPI_STALL_EN
          if (need_q) begin
            if (tx_valid) begin
              byte_q     <= tx_data;
              qd_out_q   <= tx_data[7:4];
              tx_ready_q <= 1'b1;
              need_q     <= 1'b0;
            end
          end else
`endif
          if (fall) begin
            if (nib_q) begin
              qd_out_q <= byte_q[3:0];
            end else if (tx_valid) begin
              byte_q     <= tx_data;
              qd_out_q   <= tx_data[7:4];
              tx_ready_q <= 1'b1;
            end else begin
`ifdef QSPI_STALL_EN
              need_q   <= 1'b1;
`else
              byte_q   <= '0;
              qd_out_q <= '0;
              err_q    <= 1'b1;
`endif
            end
          end else if (rise) begin
            nib_q <= ~nib_q;
            if (nib_q) begin
              rem_q <= rem_q - LEN_ONE;
              if (rem_q == LEN_ONE) state_q <= ST_HOLD;
            end
          end
        end
        ST_TURN: if (fall) begin
          qd_oe_q <= '0;
          if (turn_q == TURN_LAST) state_q <= ST_RDATA;
          else                     turn_q  <= turn_q + TURN_W'(1);
        end
        ST_RDATA: if (rise) begin
          nib_q <= ~nib_q;
          if (!nib_q) begin
            byte_q[7:4] <= qd_in;
          end else begin
            rx_data_q  <= {byte_q[7:4], qd_in};
            rx_valid_q <= 1'b1;
`ifndef QSPI_STALL_EN
            if (rx_valid_q && !rx_ready) err_q <= 1'b1;
`endif
            rem_q <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) state_q <= ST_HOLD;
          end
        end
        ST_HOLD: if (tick && !qck) begin
          qd_oe_q <= '0;
          qss_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_DESEL;
        end
        ST_DESEL: if (tick) begin
          nib_q <= ~nib_q;
          if (nib_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign qss       = qss_q;
  assign qd_out    = qd_out_q;
  assign qd_oe     = qd_oe_q;

endmodule
`default_nettype wire
